// File: rtl/mac_loopback_buffer.sv
// Frame loopback engine: stores received GMII-style frames in a circular buffer and
// replays each good frame with carrier deferral, inter-frame gap and collision retry.
// Optional macro LOOPBACK_ADDR_SWAP_EN swaps destination/source MAC addresses on replay.
module mac_loopback_buffer #(
  parameter int DEPTH_LOG2  = 10,
  parameter int MAX_FRAMES  = 4,
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_LEN     = 14,
  parameter int RETRY_LIMIT = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx_data_valid,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_error,
  input  logic                        carrier_sense,
  input  logic                        collision,
  output logic                        tx_enable,
  output logic [7:0]                  tx_data,
  output logic [$clog2(MAX_FRAMES):0] frames_queued,
  output logic                        drop_pulse
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int QW    = $clog2(MAX_FRAMES);
  localparam int GW    = $clog2(IFG_CYCLES + 1);
  localparam int RW    = $clog2(RETRY_LIMIT + 2);

  localparam logic [DEPTH_LOG2:0] MIN_LEN_W = (DEPTH_LOG2 + 1)'(MIN_LEN);
  localparam logic [DEPTH_LOG2:0] IDX_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [QW:0]         Q_FULL    = (QW + 1)'(MAX_FRAMES);
  localparam logic [GW-1:0]       GAP_LAST  = GW'(IFG_CYCLES - 1);
  localparam logic [RW-1:0]       RETRY_MAX = RW'(RETRY_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DEFER = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] commit_ptr;
  logic [DEPTH_LOG2-1:0] tx_start;
  logic [DEPTH_LOG2:0]   rx_len;
  logic                  in_frame;
  logic                  rx_err;
  logic                  rx_ovf;

  logic [DEPTH_LOG2:0]   len_q [MAX_FRAMES];
  logic [QW-1:0]         q_head;
  logic [QW-1:0]         q_tail;
  logic [QW:0]           q_count;

  logic [1:0]            state;
  logic [GW-1:0]         gap_cnt;
  logic [RW-1:0]         retry_cnt;
  logic [DEPTH_LOG2:0]   tx_idx;

  logic                  ovf_now;
  logic                  wr_en;
  logic                  frame_end;
  logic                  commit_ok;
  logic                  push;
  logic                  pop;
  logic                  rx_drop;
  logic                  retry_over;
  logic                  send_done;
  logic [DEPTH_LOG2:0]   head_len;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [DEPTH_LOG2-1:0] fetch_off;
  logic [DEPTH_LOG2-1:0] fetch_addr;

  // Buffer is full when the next write reaches the tx head while anything is held;
  // the queue count disambiguates full from empty when the pointers meet.
  assign ovf_now   = (wr_ptr == tx_start) && ((q_count != '0) || (rx_len != '0));
  assign wr_en     = rx_data_valid && !rx_ovf && !ovf_now;
  assign frame_end = in_frame && !rx_data_valid;
  assign commit_ok = !rx_err && !rx_ovf && !rx_len[DEPTH_LOG2] &&
                     (rx_len >= MIN_LEN_W) && (q_count != Q_FULL);
  assign push      = frame_end && commit_ok;
  assign rx_drop   = frame_end && !commit_ok;

  assign head_len   = len_q[q_head];
  assign send_done  = (state == ST_SEND) && !collision && (tx_idx == head_len);
  assign retry_over = (state == ST_SEND) && collision && (retry_cnt >= RETRY_MAX);
  assign pop        = send_done || retry_over;

  assign fetch_idx = (state == ST_SEND) ? tx_idx[DEPTH_LOG2-1:0] : '0;

`ifdef LOOPBACK_ADDR_SWAP_EN
  localparam logic [DEPTH_LOG2-1:0] SIX    = DEPTH_LOG2'(6);
  localparam logic [DEPTH_LOG2-1:0] TWELVE = DEPTH_LOG2'(12);

  always_comb begin
    fetch_off = fetch_idx;
    if (fetch_idx < SIX)
      fetch_off = fetch_idx + SIX;
    else if (fetch_idx < TWELVE)
      fetch_off = fetch_idx - SIX;
  end
`else
  assign fetch_off = fetch_idx;
`endif

  assign fetch_addr    = tx_start + fetch_off;
  assign frames_queued = q_count;

  always_ff @(posedge clock) begin
    if (wr_en && !reset)
      mem[wr_ptr] <= rx_data;
  end

  // Receive side: a frame is validated on its first idle cycle, then either
  // committed or discarded by rewinding the write pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rx_len     <= '0;
      in_frame   <= 1'b0;
      rx_err     <= 1'b0;
      rx_ovf     <= 1'b0;
    end else if (rx_data_valid) begin
      in_frame <= 1'b1;
      if (rx_error)
        rx_err <= 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        rx_len <= rx_len + 1'b1;
      end else begin
        rx_ovf <= 1'b1;
      end
    end else if (in_frame) begin
      in_frame <= 1'b0;
      rx_err   <= 1'b0;
      rx_ovf   <= 1'b0;
      rx_len   <= '0;
      if (commit_ok)
        commit_ptr <= wr_ptr;
      else
        wr_ptr <= commit_ptr;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset)
      len_q[q_tail] <= rx_len;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (push)
        q_tail <= q_tail + 1'b1;
      if (pop)
        q_head <= q_head + 1'b1;
      if (push && !pop)
        q_count <= q_count + 1'b1;
      else if (pop && !push)
        q_count <= q_count - 1'b1;
    end
  end

  // Transmit FSM; tx_data is loaded one cycle ahead so the first byte is
  // fetched on the last gap cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      retry_cnt  <= '0;
      tx_idx     <= '0;
      tx_start   <= '0;
      tx_enable  <= 1'b0;
      tx_data    <= 8'h00;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= rx_drop || retry_over;
      case (state)
        ST_IDLE: begin
          if (q_count != '0)
            state <= ST_DEFER;
        end
        ST_DEFER: begin
          if (!carrier_sense) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (carrier_sense) begin
            state <= ST_DEFER;
          end else if (gap_cnt == GAP_LAST) begin
            state     <= ST_SEND;
            tx_enable <= 1'b1;
            tx_data   <= mem[fetch_addr];
            tx_idx    <= IDX_ONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (collision) begin
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            tx_idx    <= '0;
            if (retry_over) begin
              retry_cnt <= '0;
              tx_start  <= tx_start + head_len[DEPTH_LOG2-1:0];
              state     <= ST_IDLE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_DEFER;
            end
          end else if (send_done) begin
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            tx_idx    <= '0;
            retry_cnt <= '0;
            tx_start  <= tx_start + head_len[DEPTH_LOG2-1:0];
            state     <= ST_IDLE;
          end else begin
            tx_data <= mem[fetch_addr];
            tx_idx  <= tx_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_loopback_buffer.sv
// Self-checking bench for mac_loopback_buffer: table of single-frame vectors plus
// directed sequences for collision retry, carrier deferral, queue-full and reset.
module tb_mac_loopback_buffer;

  localparam int IFG = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       carrier_sense;
  logic       collision;
  logic       tx_enable;
  logic [7:0] tx_data;
  logic [2:0] frames_queued;
  logic       drop_pulse;

  mac_loopback_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_error      (rx_error),
    .carrier_sense (carrier_sense),
    .collision     (collision),
    .tx_enable     (tx_enable),
    .tx_data       (tx_data),
    .frames_queued (frames_queued),
    .drop_pulse    (drop_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drops = 0;
  int idle_bad = 0;
  int run_len = 0;
  logic prev_en = 1'b0;
  int starts[$];
  int runs[$];
  logic [7:0] tx_bytes[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Observes the transmit side mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (drop_pulse === 1'b1)
      drops <= drops + 1;
    if (tx_enable === 1'b1) begin
      tx_bytes.push_back(tx_data);
      if (!prev_en)
        starts.push_back(cyc);
      run_len <= run_len + 1;
    end else begin
      if (tx_data !== 8'h00)
        idle_bad <= idle_bad + 1;
      if (prev_en) begin
        runs.push_back(run_len);
        run_len <= 0;
      end
    end
    prev_en <= (tx_enable === 1'b1);
  end

  typedef struct {
    int         len;
    logic [7:0] base;
    int         err_at;
    int         exp_drop;
    int         exp_tx;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic clear_monitor();
    starts.delete();
    runs.delete();
    tx_bytes.delete();
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] base, input int idx);
    int off;
    off = idx;
`ifdef LOOPBACK_ADDR_SWAP_EN
    if (idx < 6)
      off = idx + 6;
    else if (idx < 12)
      off = idx - 6;
`endif
    return base + off[7:0];
  endfunction

  task automatic apply_stimulus(input int len, input logic [7:0] base, input int err_at);
    for (int i = 0; i < len; i++) begin
      rx_data_valid = 1'b1;
      rx_data       = base + i[7:0];
      rx_error      = (i == err_at);
      tick();
    end
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
    rx_error      = 1'b0;
  endtask

  task automatic wait_tx(input string name, input int bound);
    int n;
    n = 0;
    while (tx_enable !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check_output(name, {31'd0, tx_enable}, 32'd1);
  endtask

  // Waits out one replay and checks its timing and content.
  task automatic verify_frame(input string name, input int len, input logic [7:0] base, input int end_cyc);
    tick_n(2 * len + 40);
    check_output({name, "_starts"}, starts.size(), 1);
    check_output({name, "_latency"}, (starts.size() > 0) ? starts[0] : -1, end_cyc + IFG + 3);
    check_output({name, "_runlen"}, (runs.size() > 0) ? runs[0] : -1, len);
    check_output({name, "_nbytes"}, tx_bytes.size(), len);
    for (int i = 0; i < len && i < tx_bytes.size(); i++)
      check_output($sformatf("%s_byte%0d", name, i), tx_bytes[i], exp_byte(base, i));
    check_output({name, "_fq_end"}, frames_queued, 0);
  endtask

  initial begin
    int end_cyc;
    int d0;
    int r;
    int nstart;
    string nm;

    vecs[0]  = '{len: 20,   base: 8'h00, err_at: -1, exp_drop: 0, exp_tx: 1};
    vecs[1]  = '{len: 20,   base: 8'h40, err_at: 5,  exp_drop: 1, exp_tx: 0};
    vecs[2]  = '{len: 10,   base: 8'h80, err_at: -1, exp_drop: 1, exp_tx: 0};
    vecs[3]  = '{len: 16,   base: 8'h90, err_at: -1, exp_drop: 0, exp_tx: 1};
    vecs[4]  = '{len: 14,   base: 8'hA0, err_at: -1, exp_drop: 0, exp_tx: 1};
    vecs[5]  = '{len: 13,   base: 8'hB0, err_at: -1, exp_drop: 1, exp_tx: 0};
    vecs[6]  = '{len: 14,   base: 8'hC0, err_at: 13, exp_drop: 1, exp_tx: 0};
    vecs[7]  = '{len: 1024, base: 8'h00, err_at: -1, exp_drop: 1, exp_tx: 0};
    vecs[8]  = '{len: 1023, base: 8'h05, err_at: -1, exp_drop: 0, exp_tx: 1};
    vecs[9]  = '{len: 1100, base: 8'h11, err_at: -1, exp_drop: 1, exp_tx: 0};
    vecs[10] = '{len: 16,   base: 8'hD0, err_at: -1, exp_drop: 0, exp_tx: 1};

    reset = 1'b1;
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    rx_error = 1'b0;
    carrier_sense = 1'b0;
    collision = 1'b0;
    tick_n(3);
    check_output("rst_tx_enable", {31'd0, tx_enable}, 0);
    check_output("rst_tx_data", tx_data, 0);
    check_output("rst_frames_queued", frames_queued, 0);
    check_output("rst_drop_pulse", {31'd0, drop_pulse}, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      nm = $sformatf("vec%0d", v);
      clear_monitor();
      d0 = drops;
      apply_stimulus(vecs[v].len, vecs[v].base, vecs[v].err_at);
      end_cyc = cyc;
      check_output({nm, "_fq_pre"}, frames_queued, 0);
      tick();
      check_output({nm, "_fq_commit"}, frames_queued, vecs[v].exp_tx);
      check_output({nm, "_drop_pulse"}, {31'd0, drop_pulse}, vecs[v].exp_drop);
      if (vecs[v].exp_tx != 0) begin
        verify_frame(nm, vecs[v].len, vecs[v].base, end_cyc);
      end else begin
        tick_n(60);
        check_output({nm, "_no_tx"}, starts.size(), 0);
        check_output({nm, "_fq_end"}, frames_queued, 0);
      end
      check_output({nm, "_drops"}, drops - d0, vecs[v].exp_drop);
    end

    // Collision on byte 3 of every attempt: three restarts, then the frame is discarded.
    clear_monitor();
    apply_stimulus(20, 8'h10, -1);
    for (int a = 0; a < 4; a++) begin
      wait_tx($sformatf("colA%0d_wait", a), 100);
      check_output($sformatf("colA%0d_byte0", a), tx_data, exp_byte(8'h10, 0));
      tick_n(3);
      check_output($sformatf("colA%0d_byte3", a), tx_data, exp_byte(8'h10, 3));
      collision = 1'b1;
      tick();
      collision = 1'b0;
      check_output($sformatf("colA%0d_txoff", a), {31'd0, tx_enable}, 0);
      check_output($sformatf("colA%0d_drop", a), {31'd0, drop_pulse}, (a == 3) ? 1 : 0);
    end
    nstart = starts.size();
    tick_n(60);
    check_output("colA_no_more_tx", starts.size(), nstart);
    check_output("colA_attempts", nstart, 4);
    check_output("colA_fq", frames_queued, 0);

    // One collision, then collision held outside SEND, then a clean replay.
    clear_monitor();
    apply_stimulus(20, 8'h30, -1);
    wait_tx("colB_wait0", 100);
    tick_n(3);
    collision = 1'b1;
    tick();
    check_output("colB_txoff", {31'd0, tx_enable}, 0);
    wait_tx("colB_wait1", 100);
    collision = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_output($sformatf("colB_byte%0d", i), {23'd0, tx_enable, tx_data}, {23'd0, 1'b1, exp_byte(8'h30, i)});
      tick();
    end
    check_output("colB_end_txoff", {31'd0, tx_enable}, 0);
    check_output("colB_fq", frames_queued, 0);

    // Carrier held, then released with one busy cycle at gap count 7.
    clear_monitor();
    carrier_sense = 1'b1;
    apply_stimulus(20, 8'h50, -1);
    tick_n(30);
    check_output("crs_held_fq", frames_queued, 1);
    check_output("crs_held_notx", starts.size(), 0);
    carrier_sense = 1'b0;
    r = cyc;
    tick_n(8);
    carrier_sense = 1'b1;
    tick();
    carrier_sense = 1'b0;
    tick_n(60);
    check_output("crs_starts", starts.size(), 1);
    check_output("crs_start_cyc", (starts.size() > 0) ? starts[0] : -1, r + IFG + 10);
    check_output("crs_runlen", (runs.size() > 0) ? runs[0] : -1, 20);

    // Five back-to-back frames against a four-entry queue while carrier is busy.
    clear_monitor();
    carrier_sense = 1'b1;
    d0 = drops;
    for (int f = 0; f < 5; f++) begin
      apply_stimulus(16, 8'(f * 32), -1);
      tick();
    end
    check_output("b2b_drop_pulse", {31'd0, drop_pulse}, 1);
    check_output("b2b_fq_full", frames_queued, 4);
    tick_n(5);
    check_output("b2b_drops", drops - d0, 1);
    check_output("b2b_held_notx", starts.size(), 0);
    carrier_sense = 1'b0;
    r = cyc;
    tick_n(4 * (16 + IFG + 2) + 40);
    check_output("b2b_starts", starts.size(), 4);
    for (int f = 0; f < 4; f++) begin
      check_output($sformatf("b2b_start%0d", f), (starts.size() > f) ? starts[f] : -1, r + IFG + 1 + f * (16 + IFG + 2));
      check_output($sformatf("b2b_run%0d", f), (runs.size() > f) ? runs[f] : -1, 16);
      for (int i = 0; i < 16; i++)
        if (f * 16 + i < tx_bytes.size())
          check_output($sformatf("b2b_f%0d_b%0d", f, i), tx_bytes[f * 16 + i], exp_byte(8'(f * 32), i));
    end
    check_output("b2b_fq_end", frames_queued, 0);

    // Reset in the middle of a replay, then in the middle of a receive.
    clear_monitor();
    apply_stimulus(20, 8'h70, -1);
    wait_tx("rst_tx_wait", 100);
    tick_n(2);
    reset = 1'b1;
    tick();
    check_output("rst_mid_tx_enable", {31'd0, tx_enable}, 0);
    check_output("rst_mid_tx_data", tx_data, 0);
    check_output("rst_mid_fq", frames_queued, 0);
    check_output("rst_mid_drop", {31'd0, drop_pulse}, 0);
    reset = 1'b0;
    clear_monitor();
    tick_n(40);
    check_output("rst_mid_notx", starts.size(), 0);
    for (int i = 0; i < 8; i++) begin
      rx_data_valid = 1'b1;
      rx_data = 8'hF0 + i[7:0];
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rx_data_valid = 1'b0;
    rx_data = 8'h00;
    tick_n(3);
    check_output("rst_rx_fq", frames_queued, 0);
    clear_monitor();
    apply_stimulus(16, 8'hE0, -1);
    end_cyc = cyc;
    tick();
    check_output("rst_rx_fq_commit", frames_queued, 1);
    verify_frame("post_rst", 16, 8'hE0, end_cyc);

    check_output("idle_tx_data_zero", idle_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
